draw_cloud: RTL
===============

Name: draw_cloud

Overview:
Sprite overlay stage that sits directly upstream of img_cloud_rom and consumes its pixel output. It turns the VGA timing stream's hcount/vcount plus the cloud's screen position into a 14-bit ROM address, then merges the returned 12-bit pixel over the incoming background RGB. All timing signals are delayed so they stay aligned with the merged pixel. Its output feeds the next draw stage or the VGA output register.

Parameters:
WIDTH, 128, sprite width in pixels; legal range 1..128.
HEIGHT, 128, sprite height in pixels; legal range 1..128.
KEY_COLOR, 12'h0F0, ROM colour treated as transparent (used only with CLOUD_TRANSP_EN).

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
hcount_in  in  11  horizontal pixel counter
vcount_in  in  11  vertical line counter
hsync_in  in  1  horizontal sync
vsync_in  in  1  vertical sync
hblnk_in  in  1  horizontal blank
vblnk_in  in  1  vertical blank
rgb_in  in  12  background pixel
xpos  in  11  sprite left edge, screen coordinates
ypos  in  11  sprite top edge, screen coordinates
rom_addr  out  14  address to img_cloud_rom, {rel_y[6:0], rel_x[6:0]}
rom_rgb  in  12  pixel returned by img_cloud_rom, one clock after rom_addr
hcount_out, vcount_out  out  11  delayed counters
hsync_out, vsync_out, hblnk_out, vblnk_out  out  1  delayed timing signals
rgb_out  out  12  merged pixel

Behaviour:
- Reset: rst_n is asynchronous and active-low. While rst_n=0, all outputs, pipeline registers and latched positions are 0. The first registered output appears on the first clk edge after release.
- Position latch: xpos/ypos are captured into x_lat/y_lat on the cycle a vsync_in rising edge is detected (previous vsync_in=0, current=1). They are used unchanged for the whole following frame, so there is no mid-frame tearing. After reset, x_lat=y_lat=0 until the first vsync rising edge.
- Stage 1 (edge 1):
  - rel_x = hcount_in − x_lat and rel_y = vcount_in − y_lat, both 11-bit.
  - in_spr = (hcount_in ≥ x_lat) && (hcount_in < x_lat+WIDTH) && (vcount_in ≥ y_lat) && (vcount_in < y_lat+HEIGHT) && !hblnk_in && !vblnk_in.
  - Comparisons use 12-bit sums so x_lat+WIDTH cannot wrap.
  - rom_addr <= in_spr ? {rel_y[6:0], rel_x[6:0]} : 14'd0. The address is registered.
  - in_spr, timing signals and rgb_in are registered alongside it.
- Stage 2 (edge 2): the ROM registers its output. The block registers in_spr, timing and rgb again to stay aligned with rom_rgb.
- Stage 3 (edge 3): rgb_out <= in_spr_d2 ? rom_rgb : rgb_d2. All *_out timing signals are registered here.
- Latency: exactly 3 clocks from any input to the corresponding output, for every signal.
- Throughput: one pixel per clock. There is no stall or handshake.
- Sprite partially off-screen (e.g. xpos=700, WIDTH=128 on an 800-wide line):
  - Only the visible columns are drawn.
  - There is no wrap to the next line's left edge, because hcount never reaches xpos+WIDTH.
- Blanking: during blanking, rgb_out equals the delayed rgb_in, even if the sprite rectangle overlaps the blank region.
- vsync during a frame: a position change takes effect only at the next vsync rising edge. Simultaneous vsync edge and in-sprite pixel is legal; the new position applies from the following cycle.
- Reset mid-frame: the pipeline flushes to 0 immediately. Outputs stay 0 until real data propagates (3 edges after release).

Optional Feature:
Macro CLOUD_TRANSP_EN.
- Defined: stage 3 uses rgb_out <= (in_spr_d2 && rom_rgb != KEY_COLOR) ? rom_rgb : rgb_d2. Key-coloured sprite pixels show the background.
- Undefined: every in-sprite pixel shows rom_rgb, and KEY_COLOR is ignored.

Test Plan:
- Reset held, random inputs → all outputs 0. Release rst_n → first output valid at edge 3 after the inputs it reflects.
- Latch: xpos=100, ypos=50, then vsync rising edge.
  - At hcount=100, vcount=50: rom_addr=14'h0000.
  - At hcount=227, vcount=177: rom_addr=14'h3FFF.
  - At hcount=228: rgb_out=rgb_in (delayed 3).
- Timing alignment: hsync_in pulse at hcount=656 → hsync_out pulses exactly 3 clocks later. hcount_out lags hcount_in by 3.
- Mid-frame position change: xpos changed from 100 to 300 at line 200 → the sprite stays at x=100 until the next vsync rising edge, then draws at x=300.
- Edge clip: xpos=700, hcount range 0..799.
  - Sprite pixels appear only at hcount_out 700..799.
  - rgb_out=rgb_in for hcount 0..127 of the next line.
- Transparency (CLOUD_TRANSP_EN defined): rom_rgb=12'h0F0 inside the sprite → rgb_out=rgb_in.
- Same stimulus without the macro → rgb_out=12'h0F0.

Source files
------------

// File: rtl/draw_cloud.sv
// rtl/draw_cloud.sv - cloud sprite overlay: ROM address generation and pixel merge, 3-clock latency
// Optional build macro CLOUD_TRANSP_EN: treat KEY_COLOR ROM pixels as transparent.
module draw_cloud #(
    parameter int          WIDTH     = 128,
    parameter int          HEIGHT    = 128,
    parameter logic [11:0] KEY_COLOR = 12'h0F0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    input  logic [10:0] xpos,
    input  logic [10:0] ypos,
    output logic [13:0] rom_addr,
    input  logic [11:0] rom_rgb,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out
);

`ifdef CLOUD_TRANSP_EN
    localparam logic TRANSP = 1'b1;
`else
    localparam logic TRANSP = 1'b0;
`endif

    logic        r_vsync_prev;
    logic [10:0] r_x_lat, r_y_lat;

    logic        r_in_spr_d1, r_hsync_d1, r_vsync_d1, r_hblnk_d1, r_vblnk_d1;
    logic [10:0] r_hcount_d1, r_vcount_d1;
    logic [11:0] r_rgb_d1;

    logic        r_in_spr_d2, r_hsync_d2, r_vsync_d2, r_hblnk_d2, r_vblnk_d2;
    logic [10:0] r_hcount_d2, r_vcount_d2;
    logic [11:0] r_rgb_d2;

    logic [11:0] w_x_end, w_y_end;
    logic [6:0]  w_rel_x, w_rel_y;
    logic        w_in_spr, w_use_rom;

    // 12-bit end coordinates so a sprite near the right/bottom edge never wraps
    assign w_x_end  = {1'b0, r_x_lat} + 12'(WIDTH);
    assign w_y_end  = {1'b0, r_y_lat} + 12'(HEIGHT);
    assign w_rel_x  = hcount_in[6:0] - r_x_lat[6:0];
    assign w_rel_y  = vcount_in[6:0] - r_y_lat[6:0];
    assign w_in_spr = (hcount_in >= r_x_lat) && ({1'b0, hcount_in} < w_x_end) &&
                      (vcount_in >= r_y_lat) && ({1'b0, vcount_in} < w_y_end) &&
                      !hblnk_in && !vblnk_in;
    assign w_use_rom = r_in_spr_d2 && !(TRANSP && (rom_rgb == KEY_COLOR));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vsync_prev <= 1'b0;
            r_x_lat      <= '0;
            r_y_lat      <= '0;
            rom_addr     <= '0;
            r_in_spr_d1  <= 1'b0;
            r_hsync_d1   <= 1'b0;
            r_vsync_d1   <= 1'b0;
            r_hblnk_d1   <= 1'b0;
            r_vblnk_d1   <= 1'b0;
            r_hcount_d1  <= '0;
            r_vcount_d1  <= '0;
            r_rgb_d1     <= '0;
            r_in_spr_d2  <= 1'b0;
            r_hsync_d2   <= 1'b0;
            r_vsync_d2   <= 1'b0;
            r_hblnk_d2   <= 1'b0;
            r_vblnk_d2   <= 1'b0;
            r_hcount_d2  <= '0;
            r_vcount_d2  <= '0;
            r_rgb_d2     <= '0;
            hcount_out   <= '0;
            vcount_out   <= '0;
            hsync_out    <= 1'b0;
            vsync_out    <= 1'b0;
            hblnk_out    <= 1'b0;
            vblnk_out    <= 1'b0;
            rgb_out      <= '0;
        end else begin
            // Position only moves on a vsync rising edge so a frame never tears
            r_vsync_prev <= vsync_in;
            if (vsync_in && !r_vsync_prev) begin
                r_x_lat <= xpos;
                r_y_lat <= ypos;
            end

            rom_addr    <= w_in_spr ? {w_rel_y, w_rel_x} : 14'd0;
            r_in_spr_d1 <= w_in_spr;
            r_hsync_d1  <= hsync_in;
            r_vsync_d1  <= vsync_in;
            r_hblnk_d1  <= hblnk_in;
            r_vblnk_d1  <= vblnk_in;
            r_hcount_d1 <= hcount_in;
            r_vcount_d1 <= vcount_in;
            r_rgb_d1    <= rgb_in;

            // Second stage covers the ROM's registered read
            r_in_spr_d2 <= r_in_spr_d1;
            r_hsync_d2  <= r_hsync_d1;
            r_vsync_d2  <= r_vsync_d1;
            r_hblnk_d2  <= r_hblnk_d1;
            r_vblnk_d2  <= r_vblnk_d1;
            r_hcount_d2 <= r_hcount_d1;
            r_vcount_d2 <= r_vcount_d1;
            r_rgb_d2    <= r_rgb_d1;

            hcount_out  <= r_hcount_d2;
            vcount_out  <= r_vcount_d2;
            hsync_out   <= r_hsync_d2;
            vsync_out   <= r_vsync_d2;
            hblnk_out   <= r_hblnk_d2;
            vblnk_out   <= r_vblnk_d2;
            rgb_out     <= w_use_rom ? rom_rgb : r_rgb_d2;
        end
    end

endmodule
